// File: rtl/dino_game_ctrl_if.sv
// Game-side signal bundle for dino_game_ctrl: game inputs from the display and
// keyboard blocks, control and status outputs to the VGA/seven-segment/sound blocks.
interface dino_game_ctrl_if #(
  parameter int NUM_OBS = 3,
  parameter int SCORE_W = 16
);
  logic                   game_tick;
  logic                   key;
  logic                   pause;
  logic [11:0]            dino_pix;
  logic [12*NUM_OBS-1:0]  obs_pix;
  logic [SCORE_W-1:0]     score;
  logic                   game_rst;
  logic                   over;
  logic                   game_hold;
  logic [SCORE_W-1:0]     hi;
  logic [3:0]             bg;
  logic                   night;
  logic                   milestone;
  logic [2:0]             state;

  modport master (
    output game_tick, key, pause, dino_pix, obs_pix, score,
    input  game_rst, over, game_hold, hi, bg, night, milestone, state
  );

  modport slave (
    input  game_tick, key, pause, dino_pix, obs_pix, score,
    output game_rst, over, game_hold, hi, bg, night, milestone, state
  );
endinterface

// File: rtl/dino_game_ctrl.sv
// Dino game-state FSM: collision detect, high score, day/night fade, milestone pulse.
// Optional pause support is enabled by defining DINO_GAME_CTRL_PAUSE_EN.
module dino_game_ctrl #(
  parameter int          NUM_OBS     = 3,
  parameter int          SCORE_W     = 16,
  parameter logic [11:0] TRANSPARENT = 12'hfff,
  parameter int          CYCLE       = 'h700,
  parameter int          NIGHT_LEN   = 'h200,
  parameter int          FADE_DIV    = 32,
  parameter int          MILESTONE   = 'h100
) (
  input  logic            clk,
  input  logic            rst,
  dino_game_ctrl_if.slave bus
);
  localparam int FC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FADE_DIV - 1);
  localparam logic [SCORE_W-1:0] CYC     = SCORE_W'(CYCLE);
  localparam logic [SCORE_W-1:0] NIGHT   = SCORE_W'(NIGHT_LEN);
  localparam logic [SCORE_W-1:0] MS      = SCORE_W'(MILESTONE);

  typedef enum logic [2:0] {
    FROZEN    = 3'd0,
    RUN       = 3'd1,
    OVER_HOLD = 3'd2,
    OVER_ARM  = 3'd3,
    RESTART   = 3'd4,
    PAUSE     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               game_rst_q, over_q, night_q, milestone_q;
  logic [SCORE_W-1:0] hi_q, prev_score;
  logic [3:0]         bg_q;
  logic [FC_W-1:0]    fade_cnt;
  logic [NUM_OBS-1:0] layer_hit;
  logic               collide, pause_rise;
  logic [SCORE_W-1:0] cyc_pos, ms_pos;

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_layer
    assign layer_hit[i] = bus.obs_pix[12*i +: 12] != TRANSPARENT;
  end
  assign collide = (bus.dino_pix != TRANSPARENT) && (|layer_hit);
  assign cyc_pos = bus.score % CYC;
  assign ms_pos  = bus.score % MS;

`ifdef DINO_GAME_CTRL_PAUSE_EN
  logic pause_q, hold_q;
  assign pause_rise = bus.pause & ~pause_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pause_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      pause_q <= bus.pause;
      hold_q  <= (state_d == PAUSE);
    end
  end
  assign bus.game_hold = hold_q;
`else
  assign pause_rise    = 1'b0;
  assign bus.game_hold = 1'b0;
`endif

  // Collision is checked before pause so a simultaneous overlap always ends the run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FROZEN:    if (bus.key) state_d = RESTART;
      RUN:       if (collide) state_d = OVER_HOLD;
                 else if (pause_rise) state_d = PAUSE;
      OVER_HOLD: if (!bus.key) state_d = OVER_ARM;
      OVER_ARM:  if (bus.key) state_d = RESTART;
      RESTART:   if (!bus.key) state_d = RUN;
      PAUSE:     if (pause_rise) state_d = RUN;
      default:   state_d = FROZEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FROZEN;
      game_rst_q  <= 1'b1;
      over_q      <= 1'b0;
      hi_q        <= '0;
      bg_q        <= 4'hf;
      night_q     <= 1'b0;
      fade_cnt    <= '0;
      prev_score  <= '0;
      milestone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      game_rst_q <= (state_d == FROZEN) || (state_d == RESTART);

      if (state_q == RUN && collide) begin
        over_q <= 1'b1;
        if (bus.score > hi_q) hi_q <= bus.score;
      end else if (state_q == OVER_ARM && bus.key) begin
        over_q <= 1'b0;
      end

      if (game_rst_q) begin
        night_q     <= 1'b0;
        bg_q        <= 4'hf;
        fade_cnt    <= '0;
        prev_score  <= '0;
        milestone_q <= 1'b0;
      end else begin
        prev_score  <= bus.score;
        milestone_q <= (bus.score != prev_score) && (ms_pos == '0) && (bus.score != '0);
        if (cyc_pos == '0 && bus.score != '0) night_q <= 1'b1;
        else if (cyc_pos == NIGHT)            night_q <= 1'b0;
        // bg walks toward the current target and saturates at either end.
        if (state_q == RUN && bus.game_tick) begin
          if (fade_cnt == FC_LAST) begin
            fade_cnt <= '0;
            if (night_q && bg_q != 4'h0)       bg_q <= bg_q - 4'd1;
            else if (!night_q && bg_q != 4'hf) bg_q <= bg_q + 4'd1;
          end else begin
            fade_cnt <= fade_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.game_rst  = game_rst_q;
  assign bus.over      = over_q;
  assign bus.hi        = hi_q;
  assign bus.bg        = bg_q;
  assign bus.night     = night_q;
  assign bus.milestone = milestone_q;
endmodule

// File: tb/tb_dino_game_ctrl.sv
// Bench for dino_game_ctrl: vector table, hand sequences for fade/milestone/pause,
// then random stimulus against a behavioural model of the game rules.
module tb_dino_game_ctrl;
  localparam logic [11:0] T  = 12'hfff;
  localparam logic [11:0] D  = 12'h000;
  localparam logic [35:0] OT = 36'hfff_fff_fff;
  localparam logic [35:0] OH = {12'h555, 12'hfff, 12'hfff};
`ifdef DINO_GAME_CTRL_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dino_game_ctrl_if #(.NUM_OBS(3), .SCORE_W(16)) bus ();
  dino_game_ctrl #(.FADE_DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model, written from the game rules.
  int          m_state, m_bg, m_fc;
  bit          m_grst, m_over, m_hold, m_night, m_ms, m_pq;
  logic [15:0] m_hi, m_prev;

  task automatic model_step();
    bit coll, rise;
    int ns, pos;
    if (!rst) begin
      m_state = 0; m_grst = 1; m_over = 0; m_hold = 0; m_hi = 0; m_bg = 15;
      m_night = 0; m_fc = 0; m_prev = 0; m_ms = 0; m_pq = 0;
      return;
    end
    coll = 0;
    if (bus.dino_pix != T)
      for (int i = 0; i < 3; i++) if (bus.obs_pix[12*i +: 12] != T) coll = 1;
    rise = PEN && bus.pause && !m_pq;
    ns = m_state;
    case (m_state)
      0: if (bus.key) ns = 4;
      1: if (coll) ns = 2; else if (rise) ns = 5;
      2: if (!bus.key) ns = 3;
      3: if (bus.key) ns = 4;
      4: if (!bus.key) ns = 1;
      5: if (rise) ns = 1;
      default: ns = 0;
    endcase
    if (m_state == 1 && coll) begin
      m_over = 1;
      if (bus.score > m_hi) m_hi = bus.score;
    end else if (m_state == 3 && bus.key) m_over = 0;
    if (m_grst) begin
      m_night = 0; m_bg = 15; m_fc = 0; m_prev = 0; m_ms = 0;
    end else begin
      m_ms = (bus.score != m_prev) && (bus.score % 'h100 == 0) && (bus.score != 0);
      m_prev = bus.score;
      if (m_state == 1 && bus.game_tick) begin
        m_fc++;
        if (m_fc == 2) begin
          m_fc = 0;
          if (m_night) m_bg = (m_bg > 0) ? m_bg - 1 : 0;
          else         m_bg = (m_bg < 15) ? m_bg + 1 : 15;
        end
      end
      pos = int'(bus.score) % 'h700;
      if (pos == 0 && bus.score != 0) m_night = 1;
      else if (pos == 'h200)          m_night = 0;
    end
    m_state = ns;
    m_grst  = (ns == 0) || (ns == 4);
    m_hold  = (ns == 5);
    m_pq    = bus.pause;
  endtask

  function automatic logic [31:0] dut_vec();
    return {4'h0, bus.state, bus.game_rst, bus.over, bus.game_hold, bus.hi, bus.bg,
            bus.night, bus.milestone};
  endfunction

  function automatic logic [31:0] model_vec();
    return {4'h0, 3'(m_state), m_grst, m_over, m_hold, m_hi, 4'(m_bg), m_night, m_ms};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.game_tick = 1'b1; cyc();
      bus.game_tick = 1'b0; cyc();
    end
  endtask

  typedef struct {
    logic rst, key;
    logic [11:0] dino;
    logic [35:0] obs;
    logic [15:0] score;
    logic [2:0] st;
    logic grst, over;
    logic [15:0] hi;
  } vec_t;
  vec_t tv[$];

  task automatic v(input logic r, k, input logic [11:0] dp, input logic [35:0] op,
                   input logic [15:0] sc, input logic [2:0] st, input logic g, o,
                   input logic [15:0] h);
    vec_t e;
    e.rst = r; e.key = k; e.dino = dp; e.obs = op; e.score = sc;
    e.st = st; e.grst = g; e.over = o; e.hi = h;
    tv.push_back(e);
  endtask

  initial begin
    int cnt;
    bus.game_tick = 0; bus.key = 0; bus.pause = 0;
    bus.dino_pix = T; bus.obs_pix = OT; bus.score = 0;

    v(0,0,T,OT,16'h000, 0,1,0,16'h000);
    v(0,0,T,OT,16'h000, 0,1,0,16'h000);
    v(1,0,T,OT,16'h000, 0,1,0,16'h000);
    v(1,1,T,OT,16'h000, 4,1,0,16'h000);
    v(1,1,D,OH,16'h000, 4,1,0,16'h000);
    v(1,1,T,OT,16'h000, 4,1,0,16'h000);
    v(1,0,T,OT,16'h000, 1,0,0,16'h000);
    v(1,0,D,OH,16'h050, 2,0,1,16'h050);
    v(1,0,T,OT,16'h050, 3,0,1,16'h050);
    v(1,1,T,OT,16'h000, 4,1,0,16'h050);
    v(1,0,T,OT,16'h000, 1,0,0,16'h050);
    v(1,0,D,OH,16'h123, 2,0,1,16'h123);
    v(1,0,T,OT,16'h040, 3,0,1,16'h123);
    v(1,1,T,OT,16'h040, 4,1,0,16'h123);
    v(1,0,T,OT,16'h040, 1,0,0,16'h123);
    v(1,0,D,OH,16'h040, 2,0,1,16'h123);
    v(1,0,T,OT,16'h040, 3,0,1,16'h123);
    v(1,1,T,OT,16'h040, 4,1,0,16'h123);
    v(1,0,T,OT,16'h040, 1,0,0,16'h123);
    v(1,1,T,OT,16'h040, 1,0,0,16'h123);
    v(1,1,D,OH,16'h040, 2,0,1,16'h123);
    v(1,1,T,OT,16'h040, 2,0,1,16'h123);
    v(1,1,T,OT,16'h040, 2,0,1,16'h123);
    v(1,0,T,OT,16'h040, 3,0,1,16'h123);
    v(1,1,T,OT,16'h040, 4,1,0,16'h123);
    v(1,0,T,OT,16'h040, 1,0,0,16'h123);
    v(1,0,D,OT,16'h040, 1,0,0,16'h123);

    foreach (tv[i]) begin
      rst = tv[i].rst; bus.key = tv[i].key; bus.dino_pix = tv[i].dino;
      bus.obs_pix = tv[i].obs; bus.score = tv[i].score;
      cyc();
      chk($sformatf("tv%0d state", i), 32'(bus.state), 32'(tv[i].st));
      chk($sformatf("tv%0d game_rst", i), 32'(bus.game_rst), 32'(tv[i].grst));
      chk($sformatf("tv%0d over", i), 32'(bus.over), 32'(tv[i].over));
      chk($sformatf("tv%0d hi", i), 32'(bus.hi), 32'(tv[i].hi));
      if (i < 3) chk($sformatf("tv%0d bg", i), 32'(bus.bg), 32'hf);
    end
    bus.dino_pix = T;

    // Night fade down and back up with FADE_DIV=2.
    bus.score = 16'h0700; cyc();
    chk("night_on", 32'(bus.night), 32'd1);
    chk("ms_0700", 32'(bus.milestone), 32'd1);
    ticks(2);  chk("bg_first_step", 32'(bus.bg), 32'he);
    ticks(40); chk("bg_floor", 32'(bus.bg), 32'h0);
    bus.score = 16'h0900; cyc();
    chk("night_off", 32'(bus.night), 32'd0);
    ticks(2);  chk("bg_rise_step", 32'(bus.bg), 32'h1);
    ticks(40); chk("bg_ceiling", 32'(bus.bg), 32'hf);

    // Milestone single pulse.
    bus.score = 16'h00ff; cyc();
    bus.score = 16'h0100; cnt = 0;
    repeat (5) begin cyc(); cnt += int'(bus.milestone); end
    chk("ms_once", 32'(cnt), 32'd1);

    // Restart, then score 0 gives no pulse.
    bus.dino_pix = D; bus.obs_pix = OH; cyc();
    bus.dino_pix = T; bus.obs_pix = OT;
    chk("over_again", 32'(bus.over), 32'd1);
    chk("hi_kept", 32'(bus.hi), 32'h123);
    cyc();
    bus.key = 1; cyc();
    bus.score = 0; bus.key = 0; cyc();
    chk("rerun_state", 32'(bus.state), 32'd1);
    cnt = 0;
    repeat (5) begin cyc(); cnt += int'(bus.milestone); end
    chk("ms_zero", 32'(cnt), 32'd0);

    // Pause.
    bus.score = 16'h0e00; cyc();
    chk("night_e00", 32'(bus.night), 32'd1);
    bus.pause = 1; cyc(); bus.pause = 0;
    chk("pause_state", 32'(bus.state), PEN ? 32'd5 : 32'd1);
    chk("pause_hold", 32'(bus.game_hold), 32'(PEN));
`ifdef DINO_GAME_CTRL_PAUSE_EN
    bus.dino_pix = D; bus.obs_pix = OH; cyc();
    bus.dino_pix = T; bus.obs_pix = OT;
    chk("pause_no_over", 32'(bus.over), 32'd0);
    chk("pause_stays", 32'(bus.state), 32'd5);
`endif
    ticks(100);
    chk("pause_bg", 32'(bus.bg), PEN ? 32'hf : 32'h0);
    bus.pause = 1; cyc(); bus.pause = 0;
    chk("unpause_state", 32'(bus.state), 32'd1);
    chk("unpause_hold", 32'(bus.game_hold), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) bus.key = ~bus.key;
      bus.game_tick = 1'($urandom_range(0, 1));
      bus.pause = ($urandom_range(0, 5) == 0);
      bus.dino_pix = ($urandom_range(0, 3) == 0) ? 12'($urandom) : T;
      for (int i = 0; i < 3; i++)
        bus.obs_pix[12*i +: 12] = ($urandom_range(0, 7) == 0) ? 12'($urandom) : T;
      r = $urandom_range(0, 9);
      if (r == 7)      bus.score = bus.score + 16'd1;
      else if (r == 8) bus.score = 16'($urandom_range(0, 31) * 'h100);
      else if (r == 9) bus.score = 16'($urandom_range(0, 4) * 'h700 + $urandom_range(0, 1) * 'h200);
      cyc();
      chk($sformatf("rand%0d", n), dut_vec(), model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
- Parametrised game-state controller for the Dino game.
- Replaces the ad-hoc over/released/froze/rst flag logic with an explicit FSM.
- Performs pixel-overlap collision detection across NUM_OBS obstacle layers, tracks the high score, and drives the day/night background fade and the score-milestone pulse.
- Sits between the sprite/obstacle display blocks, the keyboard block, and the VGA/seven-segment/sound blocks.

Parameters:
- NUM_OBS, 3, number of obstacle pixel layers checked for collision.
- SCORE_W, 16, score and high-score width.
- TRANSPARENT, 12'hfff, pixel value meaning "nothing drawn".
- CYCLE, 16'h700, day/night period in score units.
- NIGHT_LEN, 16'h200, night duration in score units (< CYCLE).
- FADE_DIV, 32, game_tick pulses per one bg brightness step.
- MILESTONE, 16'h100, score interval for the milestone pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- game_tick  in  1  one-clk-wide pulse per game step (already in clk domain).
- key  in  1  any game key held (level).
- pause  in  1  pause key held (level); used only with PAUSE_EN.
- dino_pix  in  12  dino sprite pixel at current scan position.
- obs_pix  in  12*NUM_OBS  obstacle layer pixels, layer i at [12i+11:12i].
- score  in  SCORE_W  current score from obstacle control.
- game_rst  out  1  active-high reset to game blocks.
- over  out  1  game-over scene active.
- game_hold  out  1  freeze game motion (pause).
- hi  out  SCORE_W  highest score achieved.
- bg  out  4  background brightness, 0xf = day.
- night  out  1  fade target (1 = night).
- milestone  out  1  one-clk pulse on reaching a nonzero multiple of MILESTONE.
- state  out  3  FSM state code (debug LEDs).

Behaviour:
- Reset (rst=0): state=FROZEN, game_rst=1, over=0, game_hold=0, hi=0, bg=4'hf, night=0, milestone=0, fade counter=0, prev_score=0. All outputs are registered.
- FSM codes:
  - FROZEN=0: game_rst=1. key=1 -> RESTART.
  - RUN=1: game_rst=0. collision -> OVER_HOLD and over<=1 in the same edge. If score>hi then hi<=score on that edge.
  - OVER_HOLD=2: wait for key release. key=0 -> OVER_ARM.
  - OVER_ARM=3: key=1 -> RESTART and over<=0.
  - RESTART=4: game_rst=1. key=0 -> RUN; game_rst drops on that same edge.
  - PAUSE=5: optional state, see Optional Feature.
- Collision = (dino_pix!=TRANSPARENT) AND (any layer obs_pix[i]!=TRANSPARENT). Evaluated only in RUN; ignored in every other state.
- Key held continuously through the collision: stays in OVER_HOLD. No restart without a release then a fresh press.
- Collision and pause in the same cycle: collision wins.
- Day/night decision, only while game_rst=0:
  - night<=1 when score%CYCLE==0 and score!=0.
  - night<=0 when score%CYCLE==NIGHT_LEN.
  - Non-power-of-two CYCLE is legal.
- Fade:
  - Fade counter increments on game_tick only in state RUN.
  - On reaching FADE_DIV-1 the counter wraps to 0, and bg steps one toward the target (0x0 if night, 0xf if not).
  - bg saturates at 0 and 0xf; never wraps.
- game_rst=1 forces night=0, bg=0xf, fade counter=0, prev_score=0. hi is retained.
- Milestone:
  - prev_score registered every clk.
  - milestone=1 for exactly one clk when score!=prev_score, score%MILESTONE==0, and score!=0.
  - Forced to 0 when game_rst=1.
- Latency: collision -> over is 1 clk. Key edge -> state change is 1 clk.

Optional Feature:
- Macro: DINO_GAME_CTRL_PAUSE_EN.
- With the macro:
  - pause is edge-detected on the rising edge.
  - RUN + rising edge -> PAUSE, game_hold<=1.
  - PAUSE + rising edge -> RUN, game_hold<=0.
  - PAUSE ignores collision, freezes the fade counter and bg, and does not assert game_rst.
- Without the macro: pause is ignored, game_hold is constant 0, and code 5 is unreachable.

Test Plan:
- rst=0 for 2 clk, then rst=1 with key=0 -> state=0, game_rst=1, bg=4'hf, hi=0. Pulse key=1 for 3 clk then 0 -> state 4 while held, state 1 with game_rst=0 one clk after release.
- RUN, score=16'h0123, hi=16'h0050, dino_pix=12'h000 and layer 2 = 12'h555 for 1 clk -> over=1, state=2, hi=16'h0123. Repeat with score=16'h0040 -> hi stays 16'h0123.
- Collision while key=1 held -> state remains 2 until key=0 (state 3). Next key=1 -> state 4, over=0. dino non-transparent but all layers 12'hfff -> no collision.
- score stepped to 16'h0700 in RUN with FADE_DIV=2 -> night=1, bg decrements every 2 game_ticks to 0 and holds. score=16'h0900 -> night=0, bg rises to 4'hf and saturates.
- score 16'h00ff->16'h0100 held 5 clk -> milestone high exactly 1 clk. score 0 after restart -> no pulse.
- With DINO_GAME_CTRL_PAUSE_EN: pause edge in RUN -> state 5, game_hold=1, an overlap pixel does not set over, bg unchanged over 100 game_ticks. Second edge -> state 1. Without the macro the same stimulus leaves state=1 and game_hold=0.
